// File: rtl/jt51_i2s_tx.sv
// I2S transmitter for the jt51 stereo accumulator output, double-buffered with sticky overrun/underrun flags.
// Define JT51_I2S_LJ_EN to emit left-justified frames instead of standard I2S.
module jt51_i2s_tx #(
    parameter int WIDTH = 16,
    parameter int SLOT  = 32,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_stb,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             clr_flags,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             frame_start,
    output logic             overrun,
    output logic             underrun
);
    localparam int BW = $clog2(2 * SLOT);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] SLOT_W   = BW'(SLOT);
    localparam logic [BW-1:0] LAST_W   = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] ONE_B    = BW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] ONE_D    = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Serial bit for slot position pos; bits shifted past the top come out as pad zeros.
    function automatic logic data_bit(input logic [WIDTH-1:0] word, input logic [BW-1:0] pos);
`ifdef JT51_I2S_LJ_EN
        logic [WIDTH-1:0] sh;
        sh = word << pos;
        return sh[WIDTH-1];
`else
        logic [WIDTH:0] sh;
        sh = {1'b0, word} << pos;
        return sh[WIDTH];
`endif
    endfunction

    state_t           state_r;
    logic [DW-1:0]    div_cnt_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] hold_left_r;
    logic [WIDTH-1:0] hold_right_r;
    logic [WIDTH-1:0] shift_left_r;
    logic [WIDTH-1:0] shift_right_r;
    logic             fresh_r;

    logic             tick_s;
    logic             fall_s;
    logic             last_s;
    logic             wrap_s;
    logic             entry_s;
    logic             load_s;
    logic [BW-1:0]    bit_nxt_s;
    logic             lr_nxt_s;
    logic [BW-1:0]    pos_s;
    logic [WIDTH-1:0] word_s;

    // Divider tick, bclk fall detection and the next serial bit selection.
    always_comb begin
        tick_s  = (div_cnt_r == DIV_LAST);
        fall_s  = (state_r == ST_RUN) && tick_s && bclk;
        last_s  = (bit_cnt_r == LAST_W);
        wrap_s  = fall_s && last_s;
        entry_s = (state_r == ST_IDLE) && enable && fresh_r;
        load_s  = entry_s || (wrap_s && enable);
        if ((state_r == ST_RUN) && !last_s) begin
            bit_nxt_s = bit_cnt_r + ONE_B;
        end else begin
            bit_nxt_s = {BW{1'b0}};
        end
        if (bit_nxt_s >= SLOT_W) begin
            lr_nxt_s = 1'b1;
            pos_s    = bit_nxt_s - SLOT_W;
        end else begin
            lr_nxt_s = 1'b0;
            pos_s    = bit_nxt_s;
        end
        // A loading fall must already emit from the new frame (matters for left-justified MSB at position 0).
        if (load_s) begin
            word_s = lr_nxt_s ? hold_right_r : hold_left_r;
        end else begin
            word_s = lr_nxt_s ? shift_right_r : shift_left_r;
        end
    end

    // Frame sequencer: divider, bit counter, serial outputs and frame loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            div_cnt_r     <= {DW{1'b0}};
            bit_cnt_r     <= {BW{1'b0}};
            shift_left_r  <= {WIDTH{1'b0}};
            shift_right_r <= {WIDTH{1'b0}};
            bclk          <= 1'b0;
            lrclk         <= 1'b0;
            sdata         <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    div_cnt_r <= {DW{1'b0}};
                    bit_cnt_r <= {BW{1'b0}};
                    bclk      <= 1'b0;
                    lrclk     <= 1'b0;
                    sdata     <= 1'b0;
                    if (entry_s) begin
                        state_r       <= ST_RUN;
                        shift_left_r  <= hold_left_r;
                        shift_right_r <= hold_right_r;
                        frame_start   <= 1'b1;
                        sdata         <= data_bit(word_s, pos_s);
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        div_cnt_r <= {DW{1'b0}};
                        bclk      <= ~bclk;
                    end else begin
                        div_cnt_r <= div_cnt_r + ONE_D;
                    end
                    if (wrap_s && !enable) begin
                        state_r   <= ST_STOP;
                        div_cnt_r <= {DW{1'b0}};
                        bit_cnt_r <= {BW{1'b0}};
                        bclk      <= 1'b0;
                        lrclk     <= 1'b0;
                        sdata     <= 1'b0;
                    end else if (fall_s) begin
                        bit_cnt_r <= bit_nxt_s;
                        lrclk     <= lr_nxt_s;
                        sdata     <= data_bit(word_s, pos_s);
                        if (load_s) begin
                            shift_left_r  <= hold_left_r;
                            shift_right_r <= hold_right_r;
                            frame_start   <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    state_r   <= ST_IDLE;
                    div_cnt_r <= {DW{1'b0}};
                    bit_cnt_r <= {BW{1'b0}};
                    bclk      <= 1'b0;
                    lrclk     <= 1'b0;
                    sdata     <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    div_cnt_r <= {DW{1'b0}};
                    bit_cnt_r <= {BW{1'b0}};
                    bclk      <= 1'b0;
                    lrclk     <= 1'b0;
                    sdata     <= 1'b0;
                end
            endcase
        end
    end

    // Holding stage; a strobe coincident with a load stays pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_left_r  <= {WIDTH{1'b0}};
            hold_right_r <= {WIDTH{1'b0}};
            fresh_r      <= 1'b0;
        end else begin
            if (sample_stb) begin
                hold_left_r  <= left_in;
                hold_right_r <= right_in;
            end
            if (load_s) begin
                fresh_r <= sample_stb;
            end else if (sample_stb) begin
                fresh_r <= 1'b1;
            end
        end
    end

    // Sticky status flags; a set event overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (sample_stb && fresh_r && !load_s) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (load_s && !fresh_r) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jt51_i2s_tx.sv
// Directed bench for jt51_i2s_tx: acts as an I2S receiver sampling sdata/lrclk on rising bclk.
module tb_jt51_i2s_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_stb;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        clr_flags;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_start;
    logic        overrun;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jt51_i2s_tx #(.WIDTH(16), .SLOT(32), .DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_stb(sample_stb),
        .left_in(left_in), .right_in(right_in), .clr_flags(clr_flags),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .overrun(overrun), .underrun(underrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
`ifdef JT51_I2S_LJ_EN
        return {l, 16'h0000, r, 16'h0000};
`else
        return {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
`endif
    endfunction

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        sample_stb = 1'b1;
        left_in    = l;
        right_in   = r;
        @(negedge clk);
        sample_stb = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic wait_fs(output int cyc);
        cyc = 0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (frame_start) break;
        end
        chk("frame_start_seen", 64'(frame_start), 64'd1);
    endtask

    task automatic collect(output logic [63:0] data, output logic [63:0] lr,
                           output int gap, output int nfs);
        int   n;
        int   cyc;
        int   first;
        logic prev;
        n = 0; cyc = 0; first = 0; gap = 0; nfs = 0;
        data = 64'd0; lr = 64'd0;
        prev = bclk;
        while (n < 64 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (frame_start) nfs++;
            if (bclk && !prev) begin
                data[63-n] = sdata;
                lr[63-n]   = lrclk;
                if (n == 0) first = cyc;
                if (n == 1) gap = cyc - first;
                n++;
            end
            prev = bclk;
        end
        chk("collect_count", 64'(n), 64'd64);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
        logic [63:0] data;
        logic [63:0] lr;
        int          gap;
        int          nfs;
        collect(data, lr, gap, nfs);
        chk({tag, "_data"}, data, frame_bits(l, r));
        chk({tag, "_lrclk"}, lr, {32'h0000_0000, 32'hFFFF_FFFF});
    endtask

    initial begin
        logic [63:0] data;
        logic [63:0] lr;
        int          gap;
        int          nfs;
        int          cyc;
        int          rises;
        int          busy;
        logic        prev;
        logic        last_lr;

        rst_n = 1'b0; enable = 1'b0; sample_stb = 1'b0; clr_flags = 1'b0;
        left_in = 16'h0000; right_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bclk, lrclk, sdata, frame_start, overrun, underrun}), 64'd0);

        rst_n = 1'b1; enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_without_sample", 64'({bclk, frame_start}), 64'd0);

        // First frame: latency, bit clock period and word layout.
        strobe(16'h8001, 16'h7FFE);
        chk("fs_not_in_strobe_cycle", 64'(frame_start), 64'd0);
        wait_fs(cyc);
        chk("fs_latency", 64'(cyc), 64'd1);
        chk("load_outputs", 64'({bclk, lrclk, sdata}), 64'd0);
        collect(data, lr, gap, nfs);
        chk("frame1_data", data, frame_bits(16'h8001, 16'h7FFE));
        chk("frame1_lrclk", lr, {32'h0000_0000, 32'hFFFF_FFFF});
        chk("bclk_period", 64'(gap), 64'd4);
        chk("frame1_no_extra_fs", 64'(nfs), 64'd0);
        chk("no_underrun_frame1", 64'(underrun), 64'd0);

        // Starved frames repeat the last words and raise underrun.
        wait_fs(cyc);
        chk("underrun_set", 64'(underrun), 64'd1);
        check_frame("repeat1", 16'h8001, 16'h7FFE);
        pulse_clr();
        chk("underrun_cleared", 64'(underrun), 64'd0);
        wait_fs(cyc);
        chk("underrun_next_frame", 64'(underrun), 64'd1);
        check_frame("repeat2", 16'h8001, 16'h7FFE);
        chk("no_overrun_yet", 64'(overrun), 64'd0);

        // Two strobes inside one frame: overrun, newest sample wins.
        wait_fs(cyc);
        strobe(16'h0001, 16'hFFFF);
        repeat (9) @(negedge clk);
        strobe(16'h0002, 16'h1234);
        chk("overrun_set", 64'(overrun), 64'd1);
        pulse_clr();
        chk("flags_cleared", 64'({overrun, underrun}), 64'd0);
        wait_fs(cyc);
        check_frame("after_overrun", 16'h0002, 16'h1234);
        chk("fresh_no_underrun", 64'(underrun), 64'd0);

        // Strobe exactly in the load cycle.
        @(negedge clk);
        strobe(16'h00AA, 16'h0055);
        chk("fs_coincident", 64'(frame_start), 64'd1);
        check_frame("coincident_old", 16'h0002, 16'h1234);
        chk("coincident_no_overrun", 64'(overrun), 64'd0);
        wait_fs(cyc);
        check_frame("coincident_new", 16'h00AA, 16'h0055);
        chk("coincident_no_overrun2", 64'(overrun), 64'd0);

        // Disable at bit 5: frame runs to bit 63, then stops.
        wait_fs(cyc);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        rises = 0; nfs = 0; last_lr = 1'b0;
        prev = bclk;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_start) nfs++;
            if (bclk && !prev) begin
                rises++;
                last_lr = lrclk;
            end
            prev = bclk;
        end
        chk("stop_remaining_bits", 64'(rises), 64'd59);
        chk("stop_last_slot_right", 64'(last_lr), 64'd1);
        chk("stop_no_new_frame", 64'(nfs), 64'd0);
        chk("stop_outputs_low", 64'({bclk, lrclk, sdata, frame_start}), 64'd0);

        // Re-enable with a fresh sample.
        enable = 1'b1;
        strobe(16'h1357, 16'h2468);
        wait_fs(cyc);
        chk("restart_latency", 64'(cyc), 64'd1);
        check_frame("restart", 16'h1357, 16'h2468);

        // Asynchronous reset at bit 40.
        wait_fs(cyc);
        repeat (160) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({bclk, lrclk, sdata, frame_start, overrun, underrun}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bclk || frame_start) busy++;
        end
        chk("idle_after_reset", 64'(busy), 64'd0);
        strobe(16'hA5A5, 16'h5A5A);
        wait_fs(cyc);
        chk("post_reset_latency", 64'(cyc), 64'd1);
        check_frame("post_reset", 16'hA5A5, 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jt51_i2s_tx.md
Name:
jt51_i2s_tx

Overview:
- Downstream of the operator accumulator: takes the exact 16-bit stereo samples it latches once per sample period (xleft/xright).
- Re-times the samples into a free-running I2S serial stream (bclk, lrclk, sdata) for an external DAC.
- Double-buffers samples so the audio sample rate and the serial frame rate may differ.
- Reports overrun/underrun via sticky flags.

Parameters:
- WIDTH, 16, sample width serialized per channel (MSB first).
- SLOT, 32, bclk cycles per channel slot; must be >= WIDTH+1.
- DIV, 2, clk cycles per bclk half-period; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active low
- enable  input  1  run request; sampled at frame boundaries
- sample_stb  input  1  one-clk pulse (accumulator c1_enters & cen) marking valid left_in/right_in
- left_in  input  WIDTH  signed left sample
- right_in  input  WIDTH  signed right sample
- clr_flags  input  1  synchronous clear of sticky flags
- bclk  output  1  serial bit clock
- lrclk  output  1  word select; 0 = left slot, 1 = right slot
- sdata  output  1  serial data; changes on bclk falling edge
- frame_start  output  1  one-clk pulse when a new frame is loaded
- overrun  output  1  sticky: second sample_stb arrived before the frame consumed the first
- underrun  output  1  sticky: frame started with no new sample (previous one repeated)

Behaviour:
- Reset (rst_n low, asynchronous): bclk=0, lrclk=0, sdata=0, frame_start=0, overrun=0, underrun=0. Holding and shift registers = 0. State = IDLE. Div and bit counters = 0. Reset mid-frame aborts the frame immediately.
- Holding stage: on sample_stb, hold_l/hold_r <= inputs and the `fresh` bit <= 1.
  - If sample_stb arrives while fresh=1 and no load occurs in the same cycle, the holding value is overwritten and overrun is set.
- Divider: div_cnt counts 0..DIV-1 in RUN; at DIV-1 it wraps and bclk toggles.
  - "Fall" = the cycle bclk goes 1->0. lrclk, sdata and bit_cnt update only on fall.
- bit_cnt: 0..2*SLOT-1, advances on fall, wraps to 0.
  - lrclk = 0 for bit_cnt < SLOT, else 1.
- I2S data placement: within a slot at position p (0..SLOT-1):
  - p = 0: sdata = 0 (trailing pad of previous slot).
  - p = 1..WIDTH: sdata = sample bit WIDTH-p.
  - p > WIDTH: sdata = 0.
- Frame load: on the fall where bit_cnt wraps to 0 (and on IDLE->RUN entry):
  - shift regs <= holding; frame_start pulses for 1 clk.
  - If fresh=1: clear fresh. Otherwise set underrun; the previous holding values are resent.
  - sample_stb coincident with the load: the load takes the old holding value and fresh stays 1 (the new sample waits for the next frame; no overrun).
- FSM:
  - IDLE: outputs 0, counters held at 0. Go to RUN when enable=1 and fresh=1; perform the frame load on entry.
  - RUN: free-running as above. At a frame wrap with enable=0, go to STOP.
  - STOP: bclk, lrclk and sdata forced to 0 for one clk, then IDLE.
  - Deasserting enable mid-frame always completes the current frame.
- Latency: sample_stb to first MSB on sdata = one frame (2*SLOT*2*DIV clk) + one bit period, maximum; minimum is one bit period after the load.
- clr_flags clears both flags. If a set event occurs in the same cycle, set wins.
- Output width rule: if WIDTH < input width, truncate LSBs. No rounding.

Optional Feature:
- JT51_I2S_LJ_EN defined: left-justified format.
  - Slot position p = 0..WIDTH-1 carries sample bit WIDTH-1-p, with no one-bit delay.
  - Pad zeros follow the sample bits.
  - Permits SLOT >= WIDTH.
- Undefined: standard I2S with the one-bit delay as above.

Test Plan:
- Reset then enable=1, one sample_stb with L=16'h8001, R=16'h7FFE (DIV=2, SLOT=32) -> frame_start 1 clk after the strobe cycle; bclk period 4 clk.
  - Left slot reads 0,1000000000000001,0x15; lrclk rises at bit 32; right slot reads 0,0111111111111110.
- No further strobes for 3 frames -> same words repeated, underrun=1 after the second frame_start. clr_flags -> underrun=0 until the next frame.
- Two strobes 10 clk apart within one frame (L=16'h0001 then 16'h0002) -> overrun=1; the next frame sends 16'h0002.
- Strobe in the exact load cycle -> the current frame sends the old sample, the next frame sends the new one, overrun stays 0.
- enable=0 at bit 5 -> the frame completes to bit 63, one STOP cycle, outputs 0, bclk static; re-enable with a fresh sample -> restarts at bit 0.
- rst_n pulsed low at bit 40 -> all outputs 0 asynchronously; after release the block stays IDLE until enable=1 and a new strobe.
- With JT51_I2S_LJ_EN, L=16'hA5A5 -> MSB appears at position 0, coincident with the lrclk fall.
